// File: rtl/ms_rr_merger_if.sv
// ----------------------------------------------------------------------------
// ms_rr_merger_if
//   Bundle of the merger's producer-side and downstream-side signals.
//
//   in_write  [FLUX]        per-stream write strobe (producer -> merger)
//   in_data   [FLUX*WIDTH]  per-stream data, stream i at [i*WIDTH +: WIDTH]
//   in_full   [FLUX]        per-stream local-queue full (merger -> producer)
//   out_write               write strobe to the downstream FIFO
//   out_data  [WIDTH]       data to the downstream FIFO
//   out_full  [FLUX]        per-flux full flag from the downstream FIFO
//
//   modport master : the environment (producers + downstream FIFO)
//   modport slave  : the merger itself
// ----------------------------------------------------------------------------
interface ms_rr_merger_if #(
  parameter int WIDTH = 8,
  parameter int FLUX  = 2
);
  logic [FLUX-1:0]       in_write;
  logic [FLUX*WIDTH-1:0] in_data;
  logic [FLUX-1:0]       in_full;
  logic                  out_write;
  logic [WIDTH-1:0]      out_data;
  logic [FLUX-1:0]       out_full;

  modport master (
    output in_write, in_data, out_full,
    input  in_full, out_write, out_data
  );

  modport slave (
    input  in_write, in_data, out_full,
    output in_full, out_write, out_data
  );
endinterface

// File: rtl/ms_rr_merger.sv
// ----------------------------------------------------------------------------
// ms_rr_merger
//   Collects FLUX independent producer streams, buffers each in a 2-entry
//   local queue and serializes them onto one write port in strict
//   round-robin flux order (0,1,..,FLUX-1,0,..). Only the downstream full
//   flag of the flux currently due is honoured; an empty or blocked due
//   flux stalls the whole merger so the interleave is never reordered.
//
//   Ports:
//     ck    : clock, rising edge
//     rst   : asynchronous active-low reset
//     bus   : ms_rr_merger_if.slave (in_write/in_data/in_full,
//             out_write/out_data/out_full)
//
//   Parameters: WIDTH (data bits), FLUX (streams, 2..8)
//
//   Build option MS_MERGE_BYPASS_EN: when defined, a write to the due flux
//   whose queue is empty and whose downstream is not full is forwarded to
//   out_data in the same cycle without being stored (0-cycle latency,
//   adds a combinational in_* -> out_* path). Undefined by default.
// ----------------------------------------------------------------------------
module ms_rr_merger #(
  parameter int WIDTH = 8,
  parameter int FLUX  = 2
) (
  input  logic           ck,
  input  logic           rst,
  ms_rr_merger_if.slave  bus
);

  localparam int PW = $clog2(FLUX);

  typedef logic [WIDTH-1:0] word_t;

  // Per-flux 2-entry queue state.
  word_t           mem     [FLUX][2];
  logic [FLUX-1:0] wr_ptr;
  logic [FLUX-1:0] rd_ptr;
  logic [1:0]      count   [FLUX];

  // Round-robin pointer: flux currently due on the output.
  logic [PW-1:0]   ptr;

  logic [FLUX-1:0] push;
  logic [FLUX-1:0] pop;
  logic            emit;     // head of queue ptr leaves this cycle
  logic            bypass;   // in_data of flux ptr forwarded directly
  logic            advance;  // a word leaves, ptr moves on
  word_t           head;
  word_t           bypass_data;

  // --------------------------------------------------------------------------
  // Emit / enqueue decisions
  // --------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default at the top of the block so
  // no path leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    head        = mem[ptr][rd_ptr[ptr]];
    bypass_data = '0;
    bypass      = 1'b0;
    emit        = (count[ptr] != 2'd0) && !bus.out_full[ptr];

`ifdef MS_MERGE_BYPASS_EN
    bypass_data = bus.in_data[int'(ptr)*WIDTH +: WIDTH];
    bypass      = (count[ptr] == 2'd0) && bus.in_write[ptr] && !bus.out_full[ptr];
`endif

    advance       = emit || bypass;
    bus.out_write = advance;
    if (emit)        bus.out_data = head;
    else if (bypass) bus.out_data = bypass_data;
    else             bus.out_data = '0;

    push = '0;
    pop  = '0;
    for (int i = 0; i < FLUX; i++) begin
      // Full is judged on registered count only: a same-cycle pop does not
      // open the slot for a write in that same cycle. A bypassed word is
      // consumed directly and never stored.
      push[i] = bus.in_write[i] && (count[i] != 2'd2) &&
                !(bypass && (int'(ptr) == i));
      pop[i]  = emit && (int'(ptr) == i);
    end
  end

  always_comb begin
    bus.in_full = '0;
    for (int i = 0; i < FLUX; i++) begin
      bus.in_full[i] = (count[i] == 2'd2);
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      ptr    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FLUX; i++) begin
        count[i] <= 2'd0;
        // NOTE: the queue storage is reset too; queued data must be
        // discarded and the data registers read zero after reset.
        mem[i][0] <= '0;
        mem[i][1] <= '0;
      end
    end else begin
      if (advance) begin
        ptr <= (int'(ptr) == FLUX - 1) ? '0 : ptr + 1'b1;
      end
      for (int i = 0; i < FLUX; i++) begin
        if (push[i]) begin
          mem[i][wr_ptr[i]] <= bus.in_data[i*WIDTH +: WIDTH];
          wr_ptr[i]         <= ~wr_ptr[i];
        end
        if (pop[i]) begin
          rd_ptr[i] <= ~rd_ptr[i];
        end
        // Push needs count<2 and pop needs count>0, so this never wraps;
        // simultaneous push and pop leave the count unchanged.
        count[i] <= count[i] + {1'b0, push[i]} - {1'b0, pop[i]};
      end
    end
  end

endmodule

// File: tb/tb_ms_rr_merger.sv
// ----------------------------------------------------------------------------
// tb_ms_rr_merger
//   Directed bench for ms_rr_merger with FLUX=2, WIDTH=8. Stimulus pushes the
//   hand-derived output order into exp_q; a monitor on the falling edge pops
//   and compares every word the merger presents. Directed checks cover
//   reset, stalls, in_full timing and the optional bypass.
// ----------------------------------------------------------------------------
module tb_ms_rr_merger;

  localparam int WIDTH = 8;
  localparam int FLUX  = 2;

  logic ck;
  logic rst;

  ms_rr_merger_if #(.WIDTH(WIDTH), .FLUX(FLUX)) bus ();

  ms_rr_merger #(.WIDTH(WIDTH), .FLUX(FLUX)) dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual,
               expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  // Scoreboard monitor: every emitted word must match the next expected one.
  always @(negedge ck) begin
    if (rst === 1'b1 && bus.out_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got 0x%0h, expected no write at %0t",
                 bus.out_data, $time);
      end else begin
        check("out_data", {24'h0, bus.out_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end of stimulus");
    $fatal(1);
  end

  initial begin
    rst          = 1'b0;
    bus.in_write = '0;
    bus.in_data  = '0;
    bus.out_full = '0;

    // Reset state, visible without any clock edge.
    #2;
    check("rst_out_write", {31'h0, bus.out_write}, 32'h0);
    check("rst_out_data",  {24'h0, bus.out_data},  32'h0);
    check("rst_in_full",   {30'h0, bus.in_full},   32'h0);
    tick();
    tick();
    rst = 1'b1;

    // Interleave: same-edge writes to both fluxes, 1-cycle latency.
    bus.in_data  = {8'h22, 8'h11};
    bus.in_write = 2'b11;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    tick();
    bus.in_write = 2'b00;
    check("lat1_out_write", {31'h0, bus.out_write}, 32'h1);
    check("lat1_in_full",   {30'h0, bus.in_full},   32'h0);
    repeat (3) tick();

    // Strict order: flux1 alone must wait for flux0.
    bus.in_data  = {8'hA5, 8'h00};
    bus.in_write = 2'b10;
    tick();
    bus.in_write = 2'b00;
    for (int i = 0; i < 10; i++) begin
      check("stall_out_write", {31'h0, bus.out_write}, 32'h0);
      tick();
    end
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hA5);
    bus.in_data  = {8'h00, 8'h5A};
    bus.in_write = 2'b01;
    tick();
    bus.in_write = 2'b00;
    repeat (3) tick();

    // Per-flux backpressure on the due flux holds everything.
    bus.out_full = 2'b01;
    bus.in_data  = {8'h02, 8'h01};
    bus.in_write = 2'b11;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    tick();
    bus.in_write = 2'b00;
    for (int i = 0; i < 5; i++) begin
      check("blocked_out_write", {31'h0, bus.out_write}, 32'h0);
      tick();
    end
    bus.out_full = 2'b00;
    repeat (3) tick();

    // Queue full: third flux0 write is dropped.
    bus.out_full = 2'b11;
    bus.in_data  = {8'h40, 8'h10};
    bus.in_write = 2'b11;
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h40);
    exp_q.push_back(8'h20);
    tick();
    check("in_full_one", {30'h0, bus.in_full}, 32'h0);
    bus.in_data  = {8'h00, 8'h20};
    bus.in_write = 2'b01;
    tick();
    check("in_full_two", {30'h0, bus.in_full}, 32'h1);
    bus.in_data  = {8'h00, 8'h30};
    tick();
    bus.in_write = 2'b00;
    check("in_full_drop", {30'h0, bus.in_full}, 32'h1);
    bus.out_full = 2'b00;
    tick();
    check("in_full_fall", {30'h0, bus.in_full}, 32'h0);
    repeat (3) tick();
    // A dropped 0x30 would surface after this flux1 word.
    exp_q.push_back(8'h60);
    bus.in_data  = {8'h60, 8'h00};
    bus.in_write = 2'b10;
    tick();
    bus.in_write = 2'b00;
    repeat (4) tick();

    // Reset mid-stream: move ptr to 1, fill both queues, then reset.
    exp_q.push_back(8'h70);
    bus.in_data  = {8'h00, 8'h70};
    bus.in_write = 2'b01;
    tick();
    bus.in_write = 2'b00;
    tick();
    bus.out_full = 2'b11;
    bus.in_data  = {8'h88, 8'h77};
    bus.in_write = 2'b11;
    tick();
    bus.in_data  = {8'h00, 8'h78};
    bus.in_write = 2'b01;
    tick();
    bus.in_write = 2'b00;
    check("pre_rst_in_full", {30'h0, bus.in_full}, 32'h1);
    bus.out_full = 2'b00;
    #1;
    check("pre_rst_out_write", {31'h0, bus.out_write}, 32'h1);
    check("pre_rst_out_data",  {24'h0, bus.out_data},  32'h88);
    rst = 1'b0;
    #1;
    check("mid_rst_out_write", {31'h0, bus.out_write}, 32'h0);
    check("mid_rst_out_data",  {24'h0, bus.out_data},  32'h0);
    check("mid_rst_in_full",   {30'h0, bus.in_full},   32'h0);
    tick();
    rst = 1'b1;
    bus.in_data  = {8'hB1, 8'hB0};
    bus.in_write = 2'b11;
    exp_q.push_back(8'hB0);
    exp_q.push_back(8'hB1);
    tick();
    bus.in_write = 2'b00;
    repeat (3) tick();

`ifdef MS_MERGE_BYPASS_EN
    // Bypass: empty queues, ptr=0, word appears in the same cycle.
    exp_q.push_back(8'h33);
    bus.in_data  = {8'h00, 8'h33};
    bus.in_write = 2'b01;
    #1;
    check("bypass_out_write", {31'h0, bus.out_write}, 32'h1);
    check("bypass_out_data",  {24'h0, bus.out_data},  32'h33);
    tick();
    bus.in_write = 2'b00;
    check("bypass_not_stored", {31'h0, bus.out_write}, 32'h0);
    check("bypass_in_full",    {30'h0, bus.in_full},   32'h0);
    repeat (2) tick();
`endif

    check("scoreboard_empty", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
